// File: rtl/fft_pkg.sv
// Shared definitions for the 4-point FFT sequencer.
// Holds the FSM state encoding, the sample/twiddle RAM map, per-state
// down-counter terminal values and the fixed butterfly schedule.
package fft_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLR       = 4'd1,
    ST_WAIT_STEP = 4'd2,
    ST_LOAD      = 4'd3,
    ST_CALC1     = 4'd4,
    ST_LOADA     = 4'd5,
    ST_CALC2     = 4'd6,
    ST_WB        = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    OP_A = 2'd0,
    OP_B = 2'd1,
    OP_W = 2'd2
  } operand_e;

  // RAM map: sample k Re/Im at 2k/2k+1, twiddle w Re/Im at 8+2w/9+2w.
  localparam logic [3:0] TWID_BASE = 4'd8;

  // Down-counter load values; a state ends when its counter reaches zero.
  localparam logic [2:0] LOAD_TC  = 3'd7;
  localparam logic [2:0] CALC_TC  = 3'd2;
  localparam logic [2:0] LOADA_TC = 3'd3;
  localparam logic [2:0] WB_TC    = 3'd3;

  localparam logic [1:0] LAST_BFLY = 2'd3;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       w;
  } bfly_t;

  // Fixed radix-2 schedule: two first-stage butterflies, then two
  // second-stage ones, the last using W1.
  function automatic bfly_t bfly_entry(input logic [1:0] idx);
    bfly_t e;
    unique case (idx)
      2'd0:    e = '{a: 2'd0, b: 2'd2, w: 1'b0};
      2'd1:    e = '{a: 2'd1, b: 2'd3, w: 1'b0};
      2'd2:    e = '{a: 2'd0, b: 2'd1, w: 1'b0};
      default: e = '{a: 2'd2, b: 2'd3, w: 1'b1};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/bfly_addr_gen.sv
// Combinational RAM address generator.
// Ports:
//   bfly_idx_i  active butterfly (0..3)
//   operand_i   which operand (A, B or twiddle W)
//   part_im_i   0 = real word, 1 = imaginary word
//   mem_addr_o  RAM word address
module bfly_addr_gen
  import fft_pkg::*;
(
  input  logic [1:0] bfly_idx_i,
  input  operand_e   operand_i,
  input  logic       part_im_i,
  output logic [3:0] mem_addr_o
);

  bfly_t      entry;
  logic [3:0] base;

  always_comb begin
    entry = bfly_entry(bfly_idx_i);
    unique case (operand_i)
      OP_A:    base = {1'b0, entry.a, 1'b0};
      OP_B:    base = {1'b0, entry.b, 1'b0};
      OP_W:    base = TWID_BASE | {2'b00, entry.w, 1'b0};
      default: base = 4'd0;
    endcase
    mem_addr_o = {base[3:1], part_im_i};
  end

endmodule

// File: rtl/fft4_sequencer.sv
// Control sequencer for an in-place 4-point FFT over a shared RAM.
// Each butterfly loads W and B, computes, loads A, computes, then writes
// Y back to A and Z back to B (22 cycles). Optional single-step mode
// parks between butterflies until a ReadyIn pulse.
// Ports:
//   Clock, Reset          clock, async active-high reset
//   start                 one-cycle run request (ignored while busy)
//   step_mode, ReadyIn    single-step enable and step pulse
//   mem_addr/mem_rd/mem_wr/part_im   RAM access
//   store_*, calc_*, display_*, clear  datapath strobes
//   busy, done, bfly_idx  status
//
// state      | meaning
// IDLE       | waiting for start
// CLR        | clear datapath
// WAIT_STEP  | step mode: parked until ReadyIn
// LOAD       | load W Re/Im, B Re/Im (read + capture per part)
// CALC1      | calc_ReWB, calc_ImY, calc_ImZ
// LOADA      | load A Re/Im
// CALC2      | calc_ReZ2, calc_ReZ, calc_ReY
// WB         | write Y Re/Im to A, Z Re/Im to B
// DONE       | done pulse, back to IDLE
module fft4_sequencer
  import fft_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       step_mode,
  input  logic       ReadyIn,
  output logic [3:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       part_im,
  output logic       store_W,
  output logic       store_B,
  output logic       store_A,
  output logic       calc_ReWB,
  output logic       calc_ImY,
  output logic       calc_ImZ,
  output logic       calc_ReZ2,
  output logic       calc_ReZ,
  output logic       calc_ReY,
  output logic       display_ReY,
  output logic       display_ImY,
  output logic       display_ReZ,
  output logic       display_ImZ,
  output logic       clear,
  output logic       busy,
  output logic       done,
  output logic [1:0] bfly_idx
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] bfly_q, bfly_d;

  // Step index within a state; the counter runs down so this runs up.
  logic [2:0] ph;
  operand_e   op;
  logic       pim;
  logic       addr_en;
  logic [3:0] addr_raw;

  assign ph = ~cnt_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      bfly_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bfly_q  <= bfly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bfly_d  = bfly_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLR;
          bfly_d  = 2'd0;
        end
      end
      ST_CLR: begin
        if (step_mode) begin
          state_d = ST_WAIT_STEP;
        end else begin
          state_d = ST_LOAD;
          cnt_d   = LOAD_TC;
        end
      end
      ST_WAIT_STEP: begin
        if (ReadyIn) begin
          state_d = ST_LOAD;
          cnt_d   = LOAD_TC;
        end
      end
      ST_LOAD: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_CALC1;
          cnt_d   = CALC_TC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_CALC1: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_LOADA;
          cnt_d   = LOADA_TC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_LOADA: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_CALC2;
          cnt_d   = CALC_TC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_CALC2: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_WB;
          cnt_d   = WB_TC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WB: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (bfly_q == LAST_BFLY) begin
          state_d = ST_DONE;
          bfly_d  = 2'd0;
        end else begin
          bfly_d = bfly_q + 2'd1;
          if (step_mode) begin
            state_d = ST_WAIT_STEP;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = LOAD_TC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs decode from registered state, so an async reset clears
  // them in the same cycle and nothing half-written can follow.
  always_comb begin
    op          = OP_A;
    pim         = 1'b0;
    addr_en     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    store_W     = 1'b0;
    store_B     = 1'b0;
    store_A     = 1'b0;
    calc_ReWB   = 1'b0;
    calc_ImY    = 1'b0;
    calc_ImZ    = 1'b0;
    calc_ReZ2   = 1'b0;
    calc_ReZ    = 1'b0;
    calc_ReY    = 1'b0;
    display_ReY = 1'b0;
    display_ImY = 1'b0;
    display_ReZ = 1'b0;
    display_ImZ = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        // ph: [2] W->B, [1] Re->Im, [0] read->capture
        op      = ph[2] ? OP_B : OP_W;
        pim     = ph[1];
        addr_en = 1'b1;
        if (ph[0]) begin
          store_W = ~ph[2];
          store_B = ph[2];
        end else begin
          mem_rd = 1'b1;
        end
      end
      ST_CALC1: begin
        if (cnt_q == 3'd2)      calc_ReWB = 1'b1;
        else if (cnt_q == 3'd1) calc_ImY  = 1'b1;
        else                    calc_ImZ  = 1'b1;
      end
      ST_LOADA: begin
        op      = OP_A;
        pim     = ph[1];
        addr_en = 1'b1;
        if (ph[0]) store_A = 1'b1;
        else       mem_rd  = 1'b1;
      end
      ST_CALC2: begin
        if (cnt_q == 3'd2)      calc_ReZ2 = 1'b1;
        else if (cnt_q == 3'd1) calc_ReZ  = 1'b1;
        else                    calc_ReY  = 1'b1;
      end
      ST_WB: begin
        op      = ph[1] ? OP_B : OP_A;
        pim     = ph[0];
        addr_en = 1'b1;
        mem_wr  = 1'b1;
        unique case (ph[1:0])
          2'd0:    display_ReY = 1'b1;
          2'd1:    display_ImY = 1'b1;
          2'd2:    display_ReZ = 1'b1;
          default: display_ImZ = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  bfly_addr_gen u_addr_gen (
    .bfly_idx_i (bfly_q),
    .operand_i  (op),
    .part_im_i  (pim),
    .mem_addr_o (addr_raw)
  );

  assign mem_addr = addr_en ? addr_raw : 4'd0;
  assign part_im  = addr_en ? pim : 1'b0;
  assign clear    = (state_q == ST_CLR);
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign bfly_idx = bfly_q;

endmodule

// File: tb/tb_fft4_sequencer.sv
module tb_fft4_sequencer;

  logic       Clock, Reset, start, step_mode, ReadyIn;
  logic [3:0] mem_addr;
  logic       mem_rd, mem_wr, part_im;
  logic       store_W, store_B, store_A;
  logic       calc_ReWB, calc_ImY, calc_ImZ, calc_ReZ2, calc_ReZ, calc_ReY;
  logic       display_ReY, display_ImY, display_ReZ, display_ImZ;
  logic       clear, busy, done;
  logic [1:0] bfly_idx;

  fft4_sequencer dut (
    .Clock(Clock), .Reset(Reset), .start(start), .step_mode(step_mode),
    .ReadyIn(ReadyIn), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .part_im(part_im), .store_W(store_W), .store_B(store_B), .store_A(store_A),
    .calc_ReWB(calc_ReWB), .calc_ImY(calc_ImY), .calc_ImZ(calc_ImZ),
    .calc_ReZ2(calc_ReZ2), .calc_ReZ(calc_ReZ), .calc_ReY(calc_ReY),
    .display_ReY(display_ReY), .display_ImY(display_ImY),
    .display_ReZ(display_ReZ), .display_ImZ(display_ImZ),
    .clear(clear), .busy(busy), .done(done), .bfly_idx(bfly_idx)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Event vector bit positions.
  localparam logic [16:0] RD     = 17'b1 << 16;
  localparam logic [16:0] WR     = 17'b1 << 15;
  localparam logic [16:0] SW     = 17'b1 << 14;
  localparam logic [16:0] SB     = 17'b1 << 13;
  localparam logic [16:0] SA     = 17'b1 << 12;
  localparam logic [16:0] C_REWB = 17'b1 << 11;
  localparam logic [16:0] C_IMY  = 17'b1 << 10;
  localparam logic [16:0] C_IMZ  = 17'b1 << 9;
  localparam logic [16:0] C_REZ2 = 17'b1 << 8;
  localparam logic [16:0] C_REZ  = 17'b1 << 7;
  localparam logic [16:0] C_REY  = 17'b1 << 6;
  localparam logic [16:0] D_REY  = 17'b1 << 5;
  localparam logic [16:0] D_IMY  = 17'b1 << 4;
  localparam logic [16:0] D_REZ  = 17'b1 << 3;
  localparam logic [16:0] D_IMZ  = 17'b1 << 2;
  localparam logic [16:0] CLR    = 17'b1 << 1;
  localparam logic [16:0] DN     = 17'b1;

  // One butterfly, cycle by cycle.
  logic [16:0] step_tab [22] = '{RD, SW, RD, SW, RD, SB, RD, SB,
                                 C_REWB, C_IMY, C_IMZ,
                                 RD, SA, RD, SA,
                                 C_REZ2, C_REZ, C_REY,
                                 WR | D_REY, WR | D_IMY, WR | D_REZ, WR | D_IMZ};
  logic        pim_tab  [22] = '{0,0,1,1,0,0,1,1, 0,0,0, 0,0,1,1, 0,0,0, 0,1,0,1};
  int          slot_tab [22] = '{0,0,1,1,2,2,3,3, 0,0,0, 4,4,5,5, 0,0,0, 4,5,2,3};
  // Per butterfly: W Re, W Im, B Re, B Im, A Re, A Im word addresses.
  int          addr_tab [4][6] = '{'{8, 9, 4, 5, 0, 1},
                                   '{8, 9, 6, 7, 2, 3},
                                   '{8, 9, 2, 3, 0, 1},
                                   '{10, 11, 6, 7, 4, 5}};

  typedef struct {
    logic [16:0] v;
    logic [3:0]  addr;
    logic        pim;
    logic [1:0]  bfly;
    int          cyc;
  } exp_t;

  exp_t exp_q [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   excl_bad = 0;
  bit   sb_en = 1'b1;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [16:0] pack_ev();
    return {mem_rd, mem_wr, store_W, store_B, store_A, calc_ReWB, calc_ImY,
            calc_ImZ, calc_ReZ2, calc_ReZ, calc_ReY, display_ReY, display_ImY,
            display_ReZ, display_ImZ, clear, done};
  endfunction

  function automatic bit out_zero();
    return pack_ev() == 17'd0 && mem_addr == 4'd0 && part_im == 1'b0 &&
           busy == 1'b0 && bfly_idx == 2'd0;
  endfunction

  task automatic push_ev(input logic [16:0] v, input int addr, input logic pim,
                         input int b, input int c);
    exp_t e;
    e.v = v; e.addr = 4'(addr); e.pim = pim; e.bfly = 2'(b); e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input bit timed, input int nsteps);
    push_ev(CLR, 0, 1'b0, 0, timed ? 1 : -1);
    for (int i = 0; i < nsteps; i++) begin
      int b, k;
      b = i / 22;
      k = i % 22;
      push_ev(step_tab[k], addr_tab[b][slot_tab[k]], pim_tab[k], b,
              timed ? 2 + 22 * b + k : -1);
    end
    if (nsteps == 88) push_ev(DN, 0, 1'b0, 0, timed ? 90 : -1);
  endtask

  // Monitor: exclusivity every cycle, scoreboard pop on any active output.
  logic [16:0] act;
  exp_t        me;
  bit          chk_pim, ok;
  always @(negedge Clock) begin
    act = pack_ev();
    if ($countones(act[14:1]) > 1 || (act[16] && act[15])) begin
      excl_bad++;
      $display("FAIL exclusivity cyc=%0d strobes=%b", cyc, act);
    end
    if (sb_en && act != 17'd0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got=%b addr=%0d", cyc, act, mem_addr);
      end else begin
        me = exp_q.pop_front();
        chk_pim = |(me.v & (RD | WR | SW | SB | SA));
        ok = (act == me.v) && (bfly_idx == me.bfly) &&
             (!(me.v[16] || me.v[15]) || mem_addr == me.addr) &&
             (!chk_pim || part_im == me.pim) &&
             (me.cyc < 0 || (cyc - t_start) == me.cyc);
        if (!ok) begin
          bad++;
          $display("FAIL event off=%0d got v=%b addr=%0d im=%0d bfly=%0d want v=%b addr=%0d im=%0d bfly=%0d off=%0d",
                   cyc - t_start, act, mem_addr, part_im, bfly_idx,
                   me.v, me.addr, me.pim, me.bfly, me.cyc);
        end
      end
    end
  end

  task automatic run_plain(input bit rep, input bit rel);
    int done_off, busy_err, off;
    push_run(1'b1, 88);
    @(negedge Clock);
    if (rel) Reset = 1'b0;
    start = 1'b1;
    t_start = cyc;
    done_off = -1;
    busy_err = 0;
    for (int k = 0; k < 200 && done_off < 0; k++) begin
      @(negedge Clock);
      off = cyc - t_start;
      start = rep && (off == 9 || off == 59);
      if (!busy) busy_err++;
      if (done) done_off = off;
    end
    start = 1'b0;
    total++;
    if (done_off != 90) begin
      bad++;
      $display("FAIL done_latency got=%0d want=90", done_off);
    end
    total++;
    if (busy_err != 0) begin
      bad++;
      $display("FAIL busy_during_run low_cycles=%0d want=0", busy_err);
    end
    @(negedge Clock);
    total++;
    if (!out_zero()) begin
      bad++;
      $display("FAIL idle_after_done got busy=%0d ev=%b want all 0", busy, pack_ev());
    end
  endtask

  task automatic run_step();
    int hold_err;
    step_mode = 1'b1;
    push_run(1'b0, 88);
    @(negedge Clock);
    start = 1'b1;
    t_start = cyc;
    @(negedge Clock);
    start = 1'b0;
    @(negedge Clock);
    hold_err = 0;
    repeat (50) begin
      if (!(pack_ev() == 17'd0 && busy && bfly_idx == 2'd0 && mem_addr == 4'd0))
        hold_err++;
      @(negedge Clock);
    end
    total++;
    if (hold_err != 0) begin
      bad++;
      $display("FAIL wait_step_hold bad_cycles=%0d want=0", hold_err);
    end
    for (int b = 0; b < 4; b++) begin
      ReadyIn = 1'b1;
      @(negedge Clock);
      ReadyIn = 1'b0;
      total++;
      if (!(mem_rd && mem_addr == 4'(addr_tab[b][0]) && bfly_idx == 2'(b))) begin
        bad++;
        $display("FAIL step_load_start b=%0d got rd=%0d addr=%0d bfly=%0d want rd=1 addr=%0d bfly=%0d",
                 b, mem_rd, mem_addr, bfly_idx, addr_tab[b][0], b);
      end
      for (int k = 1; k < 22; k++) begin
        @(negedge Clock);
        if (k == 10) ReadyIn = 1'b1;
        if (k == 11) ReadyIn = 1'b0;
      end
      @(negedge Clock);
      if (b < 3) begin
        repeat (3 + b) @(negedge Clock);
      end else begin
        total++;
        if (!done) begin
          bad++;
          $display("FAIL step_done got=%0d want=1", done);
        end
      end
    end
    @(negedge Clock);
    total++;
    if (busy) begin
      bad++;
      $display("FAIL step_busy_after got=%0d want=0", busy);
    end
    step_mode = 1'b0;
  endtask

  task automatic run_reset_mid();
    int off;
    push_run(1'b1, 41);
    @(negedge Clock);
    start = 1'b1;
    t_start = cyc;
    off = 0;
    for (int k = 0; k < 100 && off < 42; k++) begin
      @(negedge Clock);
      start = 1'b0;
      off = cyc - t_start;
    end
    @(posedge Clock);
    #1 Reset = 1'b1;
    #1;
    total++;
    if (!out_zero()) begin
      bad++;
      $display("FAIL reset_mid_outputs got ev=%b addr=%0d busy=%0d bfly=%0d want all 0",
               pack_ev(), mem_addr, busy, bfly_idx);
    end
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_pending got=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    run_plain(1'b0, 1'b0);
  endtask

  task automatic run_random();
    bit got_done;
    sb_en = 1'b0;
    step_mode = 1'($urandom_range(0, 1));
    @(negedge Clock);
    start = 1'b1;
    got_done = 1'b0;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      @(negedge Clock);
      start = 1'b0;
      ReadyIn = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      if (done) got_done = 1'b1;
    end
    ReadyIn = 1'b0;
    step_mode = 1'b0;
    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL random_run_timeout got=0 want=1");
    end
    @(negedge Clock);
    sb_en = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    step_mode = 1'b0;
    ReadyIn = 1'b0;
    repeat (3) @(negedge Clock);
    total++;
    if (!out_zero()) begin
      bad++;
      $display("FAIL reset_state got ev=%b addr=%0d busy=%0d want all 0",
               pack_ev(), mem_addr, busy);
    end
    run_plain(1'b0, 1'b1);
    run_plain(1'b1, 1'b0);
    run_step();
    run_reset_mid();
    repeat (3) run_random();
    total++;
    if (excl_bad != 0) begin
      bad++;
      $display("FAIL exclusivity_total got=%0d want=0", excl_bad);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
